// File: rtl/mac_int_pkg.sv
// Shared types and helpers for the multi-lane integer MAC: beat payload layout
// and saturation limits for a given accumulator width and signedness.
package mac_int_pkg;

  // Upper bounds on LANES / ACC_W / TAG_W; the payload struct is sized to these
  // and each instance uses only the low slices it needs.
  localparam int unsigned MAX_LANES = 16;
  localparam int unsigned MAX_ACC_W = 64;
  localparam int unsigned MAX_TAG_W = 16;

  typedef struct packed {
    logic [MAX_LANES-1:0][MAX_ACC_W-1:0] lanes;
    logic [MAX_LANES-1:0]                ovf;
    logic [MAX_TAG_W-1:0]                tag;
  } beat_t;

  function automatic logic [MAX_ACC_W-1:0] sat_max(input logic is_signed,
                                                   input int unsigned acc_w);
    logic [MAX_ACC_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_ACC_W; i++) begin
      if (i < acc_w) m[i] = 1'b1;
    end
    if (is_signed) m[acc_w-1] = 1'b0;
    return m;
  endfunction

  function automatic logic [MAX_ACC_W-1:0] sat_min(input logic is_signed,
                                                   input int unsigned acc_w);
    logic [MAX_ACC_W-1:0] m;
    m = '0;
    if (is_signed) m[acc_w-1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mac_int_lane.sv
// One MAC lane, purely combinational: extend, multiply, accumulate at ACC_W+1
// bits, detect overflow against the ACC_W range, then wrap or clamp.
module mac_int_lane
  import mac_int_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] weight,
  input  logic [ACC_W-1:0]  acc,
  input  logic              is_signed,
  input  logic              sat,
  output logic [ACC_W-1:0]  res,
  output logic              ovf
);

  localparam int RW = ACC_W + 1;

  logic [RW-1:0]        data_x, weight_x, acc_x, prod, sum;
  logic [MAX_ACC_W-1:0] lim_hi, lim_lo;
  logic                 unused_lim;

  // The true product fits in 2*DATA_W signed bits, so an RW-bit product and sum
  // are exact for both signednesses.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here via unconditional assignment before the override) so no latch forms.
    data_x   = {{(RW-DATA_W){is_signed & data[DATA_W-1]}}, data};
    weight_x = {{(RW-DATA_W){is_signed & weight[DATA_W-1]}}, weight};
    acc_x    = {is_signed & acc[ACC_W-1], acc};
    prod     = data_x * weight_x;
    sum      = acc_x + prod;
    ovf      = is_signed ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    lim_hi   = sat_max(is_signed, ACC_W);
    lim_lo   = sat_min(is_signed, ACC_W);
    res      = sum[ACC_W-1:0];
    if (sat && ovf) begin
      // Unsigned results are never negative, so only the signed case can go low.
      res = (is_signed && sum[ACC_W]) ? lim_lo[ACC_W-1:0] : lim_hi[ACC_W-1:0];
    end
  end

  assign unused_lim = ^{lim_hi, lim_lo};

endmodule

// File: rtl/mac_int_multilane.sv
// LANES-wide integer MAC with an elastic STAGES-deep result pipeline, flush,
// and a tag carried alongside each beat.
module mac_int_multilane
  import mac_int_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [LANES*DATA_W-1:0] data_i,
  input  logic [LANES*DATA_W-1:0] weight_i,
  input  logic [LANES*ACC_W-1:0]  acc_i,
  input  logic                    signed_i,
  input  logic                    sat_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic                    flush_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [LANES*ACC_W-1:0]  acc_o,
  output logic [LANES-1:0]        ovf_o,
  output logic [TAG_W-1:0]        tag_o,
  output logic                    busy_o
);

  logic [LANES*ACC_W-1:0] lane_res;
  logic [LANES-1:0]       lane_ovf;
  beat_t                  in_beat;
  beat_t                  pay   [STAGES];
  beat_t                  src   [STAGES];
  logic [STAGES-1:0]      vld, adv, src_v;
  logic                   chain;
  logic                   unused_pay;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_int_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .data      (data_i[l*DATA_W +: DATA_W]),
      .weight    (weight_i[l*DATA_W +: DATA_W]),
      .acc       (acc_i[l*ACC_W +: ACC_W]),
      .is_signed (signed_i),
      .sat       (sat_i),
      .res       (lane_res[l*ACC_W +: ACC_W]),
      .ovf       (lane_ovf[l])
    );
  end

  always_comb begin
    in_beat = '0;
    for (int l = 0; l < LANES; l++) begin
      in_beat.lanes[l][ACC_W-1:0] = lane_res[l*ACC_W +: ACC_W];
    end
    in_beat.ovf[LANES-1:0] = lane_ovf;
    in_beat.tag[TAG_W-1:0] = tag_i;
  end

  // Advance enables ripple back from the output; valid_i never enters this chain.
  always_comb begin
    adv   = '0;
    chain = !vld[STAGES-1] || ready_i;
    adv[STAGES-1] = chain;
    for (int k = STAGES-2; k >= 0; k--) begin
      chain  = !vld[k] || chain;
      adv[k] = chain;
    end
  end

  assign ready_o = adv[0] && !flush_i;

  always_comb begin
    src[0]   = in_beat;
    src_v[0] = valid_i && ready_o;
    for (int k = 1; k < STAGES; k++) begin
      src[k]   = pay[k-1];
      src_v[k] = vld[k-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its source's pre-edge value; blocking here would collapse the pipeline.
    if (rst_i) begin
      vld <= '0;
      // NOTE: payload registers are reset too (not just the valids) so no stale
      // operand data survives a reset, at the cost of reset fan-out.
      for (int k = 0; k < STAGES; k++) pay[k] <= '0;
    end else if (flush_i) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld[k] <= src_v[k];
          if (src_v[k]) pay[k] <= src[k];
        end
      end
    end
  end

  assign valid_o = vld[STAGES-1];
  assign busy_o  = |vld;

  always_comb begin
    acc_o = '0;
    ovf_o = '0;
    tag_o = '0;
    if (valid_o) begin
      for (int l = 0; l < LANES; l++) begin
        acc_o[l*ACC_W +: ACC_W] = pay[STAGES-1].lanes[l][ACC_W-1:0];
      end
      ovf_o = pay[STAGES-1].ovf[LANES-1:0];
      tag_o = pay[STAGES-1].tag[TAG_W-1:0];
    end
  end

  assign unused_pay = ^pay[STAGES-1];

endmodule

// File: tb/tb_mac_int_multilane.sv
// Directed bench for mac_int_multilane (4 lanes, 8-bit operands, 32-bit acc,
// 2 stages) with hand-computed per-lane results.
module tb_mac_int_multilane;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [31:0]  data_i = '0;
  logic [31:0]  weight_i = '0;
  logic [127:0] acc_i = '0;
  logic         signed_i = 1'b0;
  logic         sat_i = 1'b0;
  logic [3:0]   tag_i = '0;
  logic         flush_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic [127:0] acc_o;
  logic [3:0]   ovf_o;
  logic [3:0]   tag_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  mac_int_multilane #(
    .LANES(4), .DATA_W(8), .ACC_W(32), .STAGES(2), .TAG_W(4)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .weight_i (weight_i),
    .acc_i    (acc_i),
    .signed_i (signed_i),
    .sat_i    (sat_i),
    .tag_i    (tag_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .acc_o    (acc_o),
    .ovf_o    (ovf_o),
    .tag_o    (tag_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One isolated beat: accept, 2-cycle latency, payload check, then idle zeros.
  task automatic do_single_beat(input string name, input logic [31:0] d, w,
                                input logic [127:0] a, input logic sg, st,
                                input logic [3:0] tg, input logic [127:0] exp_acc,
                                input logic [3:0] exp_ovf);
    data_i = d; weight_i = w; acc_i = a; signed_i = sg; sat_i = st; tag_i = tg;
    valid_i = 1'b1; ready_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL %s_ready: got %b expected 1", name, ready_o);
    end
    step();
    valid_i = 1'b0; signed_i = ~sg; sat_i = ~st; tag_i = ~tg; data_i = ~d; acc_i = ~a;
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL %s_early: valid_o got %b expected 0", name, valid_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b1) begin
      errors++; $display("FAIL %s_latency: valid_o got %b expected 1", name, valid_o);
    end
    checks++;
    if (acc_o !== exp_acc) begin
      errors++; $display("FAIL %s_acc: got %h expected %h", name, acc_o, exp_acc);
    end
    checks++;
    if (ovf_o !== exp_ovf) begin
      errors++; $display("FAIL %s_ovf: got %b expected %b", name, ovf_o, exp_ovf);
    end
    checks++;
    if (tag_o !== tg) begin
      errors++; $display("FAIL %s_tag: got %h expected %h", name, tag_o, tg);
    end
    step();
    checks++;
    if ({valid_o, acc_o, ovf_o, tag_o} !== 137'd0) begin
      errors++;
      $display("FAIL %s_idle: valid_o %b acc_o %h ovf_o %b tag_o %h expected all 0",
               name, valid_o, acc_o, ovf_o, tag_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    step();
    checks++;
    if ({valid_o, busy_o, ovf_o, tag_o} !== 10'd0 || acc_o !== 128'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid_o %b busy_o %b acc_o %h ovf_o %b tag_o %h expected 0",
               valid_o, busy_o, acc_o, ovf_o, tag_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", ready_o);
    end
  endtask

  task automatic test_signed();
    do_single_beat("signed", 32'h7F0580FD, 32'h7FFE8007,
                   128'hFFFFFFFF_00000100_00000000_0000000A, 1'b1, 1'b0, 4'h3,
                   128'h00003F00_000000F6_00004000_FFFFFFF5, 4'b0000);
  endtask

  task automatic test_unsigned();
    do_single_beat("unsigned", 32'h7F0580FD, 32'h7FFE8007,
                   128'hFFFFFFFF_00000100_00000000_0000000A, 1'b0, 1'b0, 4'h5,
                   128'h00003F00_000005F6_00004000_000006F5, 4'b1000);
  endtask

  task automatic test_overflow();
    do_single_beat("ovf_sat", 32'h0102FF01, 32'h01030101,
                   128'h7FFFFFFE_00000000_80000000_7FFFFFFF, 1'b1, 1'b1, 4'h6,
                   128'h7FFFFFFF_00000006_80000000_7FFFFFFF, 4'b0011);
    do_single_beat("ovf_wrap", 32'h0102FF01, 32'h01030101,
                   128'h7FFFFFFE_00000000_80000000_7FFFFFFF, 1'b1, 1'b0, 4'h7,
                   128'h7FFFFFFF_00000006_7FFFFFFF_80000000, 4'b0011);
    do_single_beat("ovf_usat", 32'hFFFF0100, 32'hFFFF0100,
                   128'hFFFF0000_00000000_FFFFFFFF_FFFFFFFF, 1'b0, 1'b1, 4'h8,
                   128'hFFFFFE01_0000FE01_FFFFFFFF_FFFFFFFF, 4'b0010);
  endtask

  // Tags 0..3 offered back to back with ready_i low for the first 3 cycles.
  task automatic test_backpressure();
    int           n_acc = 0;
    int           n_out = 0;
    logic         prev_stall = 1'b0;
    logic         took;
    logic [3:0]   prev_tag = '0;
    logic [127:0] prev_acc = '0;
    logic [127:0] exp_acc;
    signed_i = 1'b0; sat_i = 1'b0; acc_i = '0; weight_i = 32'h01010101;
    for (int c = 0; c < 30 && n_out < 4; c++) begin
      ready_i = (c >= 3);
      valid_i = (n_acc < 4);
      tag_i   = 4'(n_acc);
      for (int l = 0; l < 4; l++) data_i[l*8 +: 8] = 8'(n_acc*4 + l + 1);
      #1;
      if (c == 2) begin
        checks++;
        if (ready_o !== 1'b0) begin
          errors++; $display("FAIL bp_ready_full: got %b expected 0", ready_o);
        end
      end
      if (prev_stall) begin
        checks++;
        if (valid_o !== 1'b1 || tag_o !== prev_tag || acc_o !== prev_acc) begin
          errors++;
          $display("FAIL bp_stable: valid_o %b tag_o %h acc_o %h expected 1 %h %h",
                   valid_o, tag_o, acc_o, prev_tag, prev_acc);
        end
      end
      if (valid_o && ready_i) begin
        for (int l = 0; l < 4; l++) exp_acc[l*32 +: 32] = 32'(n_out*4 + l + 1);
        checks++;
        if (tag_o !== 4'(n_out) || acc_o !== exp_acc) begin
          errors++;
          $display("FAIL bp_order: tag_o %h acc_o %h expected %h %h",
                   tag_o, acc_o, 4'(n_out), exp_acc);
        end
        n_out++;
      end
      prev_stall = valid_o && !ready_i;
      prev_tag   = tag_o;
      prev_acc   = acc_o;
      took       = valid_i && ready_o;
      step();
      if (took) n_acc++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    checks++;
    if (n_out != 4) begin
      errors++; $display("FAIL bp_count: got %0d beats expected 4", n_out);
    end
  endtask

  task automatic test_flush();
    ready_i = 1'b1; signed_i = 1'b0; sat_i = 1'b0;
    data_i = 32'h01010101; weight_i = 32'h01010101; acc_i = '0;
    valid_i = 1'b1; tag_i = 4'hA;
    step();
    tag_i = 4'hB;
    step();
    tag_i = 4'hC; flush_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b expected 0", ready_o);
    end
    checks++;
    if (valid_o !== 1'b1 || tag_o !== 4'hA) begin
      errors++; $display("FAIL flush_out: valid_o %b tag_o %h expected 1 a", valid_o, tag_o);
    end
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_clear: valid_o %b busy_o %b expected 0 0", valid_o, busy_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_stale: valid_o %b busy_o %b expected 0 0", valid_o, busy_o);
    end
    do_single_beat("post_flush", 32'h02020202, 32'h03030303, 128'd0, 1'b0, 1'b0, 4'hD,
                   128'h00000006_00000006_00000006_00000006, 4'b0000);
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b1; signed_i = 1'b0; sat_i = 1'b0;
    data_i = 32'h01010101; weight_i = 32'h01010101; acc_i = '0;
    valid_i = 1'b1; tag_i = 4'h1;
    step();
    tag_i = 4'h2;
    step();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: valid_o %b busy_o %b expected 1 1", valid_o, busy_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || acc_o !== 128'd0) begin
      errors++;
      $display("FAIL rstmid_async: valid_o %b busy_o %b acc_o %h expected 0", valid_o, busy_o, acc_o);
    end
    #2;
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++; $display("FAIL rstmid_stale: valid_o %b busy_o %b expected 0 0", valid_o, busy_o);
      end
    end
    do_single_beat("post_rst", 32'h04030201, 32'h02020202, 128'd0, 1'b1, 1'b0, 4'hE,
                   128'h00000008_00000006_00000004_00000002, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_overflow();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
